// File: rtl/video_timing_gen.sv
// Free-running raster timing generator with built-in test patterns.
// Counters run only between frame boundaries; every output except the size constants is registered.
module video_timing_gen #(
  parameter int unsigned DSIZE    = 24,
  parameter int unsigned H_ACTIVE = 1920,
  parameter int unsigned H_FP     = 88,
  parameter int unsigned H_SYNC   = 44,
  parameter int unsigned H_BP     = 148,
  parameter int unsigned V_ACTIVE = 1080,
  parameter int unsigned V_FP     = 4,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 36,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter logic [DSIZE-1:0] SOLID = '0
) (
  input  logic             pclk,
  input  logic             prst_n,
  input  logic             enable,
  input  logic [1:0]       pattern_sel,
  output logic             vsync,
  output logic             hsync,
  output logic             de,
  output logic [DSIZE-1:0] data,
  output logic [23:0]      vactive,
  output logic [23:0]      hactive,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned CW      = 16;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT     = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT     = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_LO = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_HI = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SYNC_LO = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_HI = CW'(V_ACTIVE + V_FP + V_SYNC);

  // Zero-width sync pulses would make the sync windows empty.
  if (H_SYNC == 0 || V_SYNC == 0) begin : g_bad_params
    $error("video_timing_gen: H_SYNC and V_SYNC must be non-zero");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic [1:0]    pat_q;
  logic [1:0]    pat_cur;
  logic          frame_first;
  logic          frame_last;

  logic             vsync_d;
  logic             hsync_d;
  logic             de_d;
  logic [DSIZE-1:0] data_d;
  logic             frame_start_d;
  logic             busy_d;

  assign frame_first = (state == RUN) && (h_cnt == '0) && (v_cnt == '0);
  assign frame_last  = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign pat_cur     = frame_first ? pattern_sel : pat_q;

  assign vactive = 24'(V_ACTIVE);
  assign hactive = 24'(H_ACTIVE);

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (frame_last && !enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Raster counters; held at the origin while idle.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (state == RUN) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
      end else begin
        h_cnt <= h_cnt + CW'(1);
      end
    end else begin
      h_cnt <= '0;
      v_cnt <= '0;
    end
  end

  // Pattern select is captured on the first pixel of each frame.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) pat_q <= 2'd0;
    else         pat_q <= pat_cur;
  end

  always_comb begin
    vsync_d       = ~VS_POL;
    hsync_d       = ~HS_POL;
    de_d          = 1'b0;
    data_d        = '0;
    frame_start_d = 1'b0;
    busy_d        = (state_next == RUN);
    if (state == RUN) begin
      hsync_d       = (h_cnt >= H_SYNC_LO && h_cnt < H_SYNC_HI) ? HS_POL : ~HS_POL;
      vsync_d       = (v_cnt >= V_SYNC_LO && v_cnt < V_SYNC_HI) ? VS_POL : ~VS_POL;
      de_d          = (h_cnt < H_ACT) && (v_cnt < V_ACT);
      frame_start_d = frame_first;
      if (de_d) begin
        case (pat_cur)
          2'd0:    data_d = DSIZE'(h_cnt);
          2'd1:    data_d = DSIZE'(v_cnt);
          2'd2:    data_d = (h_cnt[3] ^ v_cnt[3]) ? {DSIZE{1'b1}} : '0;
          default: data_d = SOLID;
        endcase
      end
    end
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      vsync       <= ~VS_POL;
      hsync       <= ~HS_POL;
      de          <= 1'b0;
      data        <= '0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      vsync       <= vsync_d;
      hsync       <= hsync_d;
      de          <= de_d;
      data        <= data_d;
      frame_start <= frame_start_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen using a 14x7 raster (98 cycles per frame).
module tb_video_timing_gen;

  localparam int unsigned DW  = 24;
  localparam int unsigned NS  = 294;

  logic          pclk = 1'b0;
  logic          prst_n = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    pattern_sel = 2'd0;
  logic          vsync, hsync, de, frame_start, busy;
  logic [DW-1:0] data;
  logic [23:0]   vactive, hactive;

  video_timing_gen #(
    .DSIZE(DW), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .SOLID(24'hABCDEF)
  ) dut (
    .pclk(pclk), .prst_n(prst_n), .enable(enable), .pattern_sel(pattern_sel),
    .vsync(vsync), .hsync(hsync), .de(de), .data(data),
    .vactive(vactive), .hactive(hactive), .frame_start(frame_start), .busy(busy)
  );

  always #5 pclk = ~pclk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          s;
    logic        de, hs, vs, fs, busy;
    logic [23:0] data;
  } vec_t;

  vec_t vecs[$];

  logic          cap_de[NS], cap_hs[NS], cap_vs[NS], cap_fs[NS], cap_busy[NS];
  logic [DW-1:0] cap_data[NS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic add_vec(input int s, input logic de_e, input logic hs_e, input logic vs_e,
                         input logic fs_e, input logic busy_e, input logic [23:0] d_e);
    vec_t v;
    v.s = s; v.de = de_e; v.hs = hs_e; v.vs = vs_e; v.fs = fs_e; v.busy = busy_e; v.data = d_e;
    vecs.push_back(v);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_vsync"}, 32'(vsync), 32'd0);
    chk({tag, "_hsync"}, 32'(hsync), 32'd0);
    chk({tag, "_de"},    32'(de),    32'd0);
    chk({tag, "_data"},  32'(data),  32'd0);
    chk({tag, "_fs"},    32'(frame_start), 32'd0);
    chk({tag, "_busy"},  32'(busy),  32'd0);
  endtask

  initial begin
    int cnt_de, cnt_hs, cnt_vs, cnt_fs, idle_bad;

    // Expected outputs by sample index s (frame pixel p = s % 98, h = p % 14, v = p / 14).
    //       s    de hs vs fs busy data
    add_vec(  0, 1, 0, 0, 1, 1, 24'h0);
    add_vec(  5, 1, 0, 0, 0, 1, 24'h5);
    add_vec(  7, 1, 0, 0, 0, 1, 24'h7);
    add_vec(  8, 0, 0, 0, 0, 1, 24'h0);
    add_vec( 10, 0, 1, 0, 0, 1, 24'h0);
    add_vec( 11, 0, 1, 0, 0, 1, 24'h0);
    add_vec( 12, 0, 0, 0, 0, 1, 24'h0);
    add_vec( 17, 1, 0, 0, 0, 1, 24'h3);
    add_vec( 44, 1, 0, 0, 0, 1, 24'h2);
    add_vec( 56, 0, 0, 0, 0, 1, 24'h0);
    add_vec( 70, 0, 0, 1, 0, 1, 24'h0);
    add_vec( 80, 0, 1, 1, 0, 1, 24'h0);
    add_vec( 84, 0, 0, 0, 0, 1, 24'h0);
    add_vec( 97, 0, 0, 0, 0, 1, 24'h0);
    add_vec( 98, 1, 0, 0, 1, 1, 24'h0);
    add_vec(114, 1, 0, 0, 0, 1, 24'h1);
    add_vec(146, 1, 0, 0, 0, 1, 24'h3);
    add_vec(196, 1, 0, 0, 1, 1, 24'hABCDEF);
    add_vec(204, 0, 0, 0, 0, 1, 24'h0);
    add_vec(215, 1, 0, 0, 0, 1, 24'hABCDEF);
    add_vec(240, 1, 0, 0, 0, 1, 24'hABCDEF);
    add_vec(292, 0, 0, 0, 0, 1, 24'h0);
    add_vec(293, 0, 0, 0, 0, 0, 24'h0);

    // Reset state
    repeat (3) tick();
    chk_reset_values("rst");
    chk("vactive", 32'(vactive), 32'd4);
    chk("hactive", 32'(hactive), 32'd8);
    prst_n = 1'b1;
    repeat (2) tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Start: busy one cycle after enable, first pixel the cycle after that
    enable = 1'b1;
    tick();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_de",   32'(de),   32'd0);
    tick();

    // Three frames; pattern changes mid-frame and enable drops at pixel 40 of frame 2
    for (int s = 0; s < int'(NS); s++) begin
      cap_de[s] = de; cap_hs[s] = hsync; cap_vs[s] = vsync;
      cap_fs[s] = frame_start; cap_busy[s] = busy; cap_data[s] = data;
      if (s == 40)  pattern_sel = 2'd1;
      if (s == 143) pattern_sel = 2'd3;
      if (s == 236) enable = 1'b0;
      tick();
    end

    foreach (vecs[i]) begin
      automatic int s = vecs[i].s;
      chk($sformatf("s%0d_de", s),   32'(cap_de[s]),   32'(vecs[i].de));
      chk($sformatf("s%0d_hs", s),   32'(cap_hs[s]),   32'(vecs[i].hs));
      chk($sformatf("s%0d_vs", s),   32'(cap_vs[s]),   32'(vecs[i].vs));
      chk($sformatf("s%0d_fs", s),   32'(cap_fs[s]),   32'(vecs[i].fs));
      chk($sformatf("s%0d_busy", s), 32'(cap_busy[s]), 32'(vecs[i].busy));
      chk($sformatf("s%0d_data", s), 32'(cap_data[s]), 32'(vecs[i].data));
    end

    // Aggregate timing over all three frames
    cnt_de = 0; cnt_hs = 0; cnt_vs = 0; cnt_fs = 0;
    for (int s = 0; s < int'(NS); s++) begin
      cnt_de += int'(cap_de[s]);
      cnt_hs += int'(cap_hs[s]);
      cnt_vs += int'(cap_vs[s]);
      if (cap_fs[s]) begin
        cnt_fs++;
        chk($sformatf("fs_pos_%0d", s), 32'(s % 98), 32'd0);
      end
    end
    chk("de_count",    32'(cnt_de), 32'd96);
    chk("hsync_count", 32'(cnt_hs), 32'd42);
    chk("vsync_count", 32'(cnt_vs), 32'd42);
    chk("fs_count",    32'(cnt_fs), 32'd3);

    // Stopped after the frame: nothing further
    idle_bad = 0;
    repeat (20) begin
      if (de || busy || frame_start || data != '0) idle_bad++;
      tick();
    end
    chk("stopped_idle", 32'(idle_bad), 32'd0);

    // Restart with checker pattern, then reset mid-line
    pattern_sel = 2'd2;
    enable = 1'b1;
    tick();
    tick();
    chk("ck_fs",   32'(frame_start), 32'd1);
    chk("ck_de",   32'(de),   32'd1);
    chk("ck_data", 32'(data), 32'd0);
    repeat (19) tick();
    chk("ck_mid_de", 32'(de), 32'd1);
    chk("ck_mid_busy", 32'(busy), 32'd1);
    #3;
    prst_n = 1'b0;
    #1;
    chk_reset_values("async");
    enable = 1'b0;
    tick();
    prst_n = 1'b1;
    tick();
    chk_reset_values("post_rst");

    // Clean frame after reset
    enable = 1'b1;
    tick();
    chk("re_busy", 32'(busy), 32'd1);
    chk("re_de0",  32'(de),   32'd0);
    tick();
    chk("re_fs",   32'(frame_start), 32'd1);
    chk("re_de",   32'(de),   32'd1);
    repeat (10) tick();
    chk("re_hs10", 32'(hsync), 32'd1);
    chk("re_de10", 32'(de),    32'd0);
    enable = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
